// File: rtl/grid_pixel_gen.sv
// grid_pixel_gen: maps the scan position onto a ROWS x COLS board and drives
// 4-bit RGB per pixel, with cell borders, a blinking cursor and a per-frame
// board snapshot so game-logic updates never tear a frame.
module grid_pixel_gen #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int CELL_W    = 160,
    parameter int CELL_H    = 120,
    parameter int V_ACTIVE  = 480,
    parameter int BORDER    = 2,
    parameter int BLINK_DIV = 16,
    localparam int SELW     = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                     clk_d,
    input  logic                     rst,
    input  logic [9:0]               pixel_x,
    input  logic [9:0]               pixel_y,
    input  logic                     video_on,
    input  logic [2*ROWS*COLS-1:0]   board,
    input  logic [SELW-1:0]          select_position,
    input  logic                     cursor_blink_en,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue,
    output logic                     frame_tick
);

    localparam int NCELL = ROWS * COLS;
    localparam int CW    = $clog2(BLINK_DIV) + 1;

    // stage 1 state
    logic [2:0]  r_row, r_col;
    logic        r_in_grid, r_border, r_von;
    // snapshot / blink state
    logic [2*NCELL-1:0] r_board_snap;
    logic [SELW-1:0]    r_sel_snap;
    logic               r_frame_tick;
    logic [CW-1:0]      r_cnt;
    logic               r_phase;
    // stage 2 state
    logic [11:0] r_rgb;

    // combinational helpers
    logic [2:0]  w_col, w_row;
    logic [9:0]  w_xbase, w_ybase, w_xo, w_yo;
    logic        w_in_grid, w_border, w_snap;
    logic [5:0]  w_k;
    logic [1:0]  w_cell;
    logic        w_sel_hit, w_cursor_vis;
    logic [11:0] w_rgb;

    // column/row lookup by comparator chain against the cell boundaries
    always_comb begin
        w_col   = '0;
        w_xbase = '0;
        for (int unsigned c = 1; c < COLS; c++) begin
            if (pixel_x >= 10'(c * CELL_W)) begin
                w_col   = 3'(c);
                w_xbase = 10'(c * CELL_W);
            end
        end
        w_row   = '0;
        w_ybase = '0;
        for (int unsigned r = 1; r < ROWS; r++) begin
            if (pixel_y >= 10'(r * CELL_H)) begin
                w_row   = 3'(r);
                w_ybase = 10'(r * CELL_H);
            end
        end
        w_xo      = pixel_x - w_xbase;
        w_yo      = pixel_y - w_ybase;
        w_in_grid = ({1'b0, pixel_x} < 11'(COLS * CELL_W)) &&
                    ({1'b0, pixel_y} < 11'(ROWS * CELL_H));
        w_border  = (w_xo < 10'(BORDER)) || (w_yo < 10'(BORDER));
        w_snap    = (pixel_x == 10'd0) && ({1'b0, pixel_y} == 11'(V_ACTIVE));
    end

    // stage 1 pipeline register
    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_in_grid <= 1'b0;
            r_border  <= 1'b0;
            r_von     <= 1'b0;
        end else begin
            r_row     <= w_row;
            r_col     <= w_col;
            r_in_grid <= w_in_grid;
            r_border  <= w_border;
            r_von     <= video_on;
        end
    end

    // frame snapshot of board/cursor plus blink frame counter
    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_board_snap <= '0;
            r_sel_snap   <= '0;
            r_frame_tick <= 1'b0;
            r_cnt        <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_frame_tick <= w_snap;
            if (w_snap) begin
                r_board_snap <= board;
                r_sel_snap   <= select_position;
                if (r_cnt == CW'(BLINK_DIV - 1)) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // stage 2 colour selection from the snapshot, in priority order
    always_comb begin
        w_k          = 6'(r_row) * 6'(COLS) + 6'(r_col);
        w_cell       = 2'b00;
        for (int unsigned i = 0; i < NCELL; i++) begin
            if (w_k == 6'(i))
                w_cell = r_board_snap[2*i +: 2];
        end
        // sel_snap beyond the last cell can never match an in-grid index
        w_sel_hit    = (7'(r_sel_snap) == 7'(w_k));
        w_cursor_vis = !cursor_blink_en || !r_phase;
        w_rgb        = '0;
        if (!r_von || !r_in_grid)
            w_rgb = '0;
        else if (r_border)
            w_rgb = 12'h888;
        else if (w_sel_hit && w_cursor_vis)
            w_rgb = 12'h00F;
        else begin
            case (w_cell)
                2'b01:   w_rgb = 12'h0F0;
                2'b10:   w_rgb = 12'hF00;
                2'b11:   w_rgb = 12'hFF0;
                default: w_rgb = (r_row[0] ^ r_col[0]) ? 12'h000 : 12'hFFF;
            endcase
        end
    end

    // stage 2 output register
    always_ff @(posedge clk_d) begin
        if (rst)
            r_rgb <= '0;
        else
            r_rgb <= w_rgb;
    end

    assign red        = r_rgb[11:8];
    assign green      = r_rgb[7:4];
    assign blue       = r_rgb[3:0];
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_grid_pixel_gen.sv
// tb_grid_pixel_gen: directed checks of grid_pixel_gen, a 4x4 instance with a
// short blink period and a 3-column instance for the non-square cases.
module tb_grid_pixel_gen;

    logic        clk_d = 1'b0;
    logic        rst;
    logic [9:0]  px, py;
    logic        von;
    logic        blink;
    logic [31:0] board4;
    logic [3:0]  sel4;
    logic [23:0] board3;
    logic [3:0]  sel3;
    logic [3:0]  r4, g4, b4, r3, g3, b3;
    logic        tick4, tick3;

    int total = 0;
    int bad   = 0;

    always #5 clk_d = ~clk_d;

    grid_pixel_gen #(.ROWS(4), .COLS(4), .BLINK_DIV(2)) u_dut (
        .clk_d(clk_d), .rst(rst), .pixel_x(px), .pixel_y(py), .video_on(von),
        .board(board4), .select_position(sel4), .cursor_blink_en(blink),
        .red(r4), .green(g4), .blue(b4), .frame_tick(tick4)
    );

    grid_pixel_gen #(.ROWS(4), .COLS(3)) u_dut3 (
        .clk_d(clk_d), .rst(rst), .pixel_x(px), .pixel_y(py), .video_on(von),
        .board(board3), .select_position(sel3), .cursor_blink_en(blink),
        .red(r3), .green(g3), .blue(b3), .frame_tick(tick3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // present a pixel and wait until its colour is on the outputs
    task automatic move(input int x, input int y);
        @(negedge clk_d);
        px = 10'(x);
        py = 10'(y);
        @(negedge clk_d);
        @(negedge clk_d);
    endtask

    // take one snapshot and check the one-cycle frame_tick pulse
    task automatic snap();
        @(negedge clk_d);
        px = 10'd0;
        py = 10'd480;
        @(negedge clk_d);
        check("tick4_hi", 32'(tick4), 32'd1);
        check("tick3_hi", 32'(tick3), 32'd1);
        px = 10'd1;
        py = 10'd0;
        @(negedge clk_d);
        check("tick4_lo", 32'(tick4), 32'd0);
    endtask

    logic [11:0] blink_exp [4];

    initial begin
        blink_exp = '{12'h00F, 12'h0F0, 12'h0F0, 12'h00F};
        rst = 1'b1; von = 1'b1; px = 10'd10; py = 10'd10; blink = 1'b0;
        board4 = '0; sel4 = 4'd15; board3 = '0; sel3 = 4'd12;

        // reset held three cycles with video on
        repeat (3) begin
            @(negedge clk_d);
            check("rst_rgb", 32'({r4, g4, b4}), 32'h0);
            check("rst_tick", 32'(tick4), 32'd0);
        end
        rst = 1'b0;
        von = 1'b0;
        repeat (3) begin
            @(negedge clk_d);
            check("von0_rgb", 32'({r4, g4, b4}), 32'h0);
        end

        // empty board, cursor parked on cell 15, steady
        von = 1'b1;
        snap();
        move(10, 10);   check("empty_00",  32'({r4, g4, b4}), 32'hFFF);
        move(200, 10);  check("empty_01",  32'({r4, g4, b4}), 32'h000);
        move(200, 130); check("empty_11",  32'({r4, g4, b4}), 32'hFFF);
        move(0, 0);     check("border",    32'({r4, g4, b4}), 32'h888);

        // mid-frame board change waits for the next snapshot
        board4 = 32'h0000_0800;
        move(200, 130); check("pre_snap",  32'({r4, g4, b4}), 32'hFFF);
        snap();
        move(200, 130); check("post_snap", 32'({r4, g4, b4}), 32'hF00);

        // reset mid-frame, then blink sequence from a clean counter
        @(negedge clk_d);
        rst = 1'b1;
        @(negedge clk_d);
        check("midrst_rgb", 32'({r4, g4, b4}), 32'h0);
        rst = 1'b0;
        board4 = 32'h1;
        sel4 = 4'd0;
        blink = 1'b1;
        for (int f = 0; f < 4; f++) begin
            snap();
            move(10, 10);
            check($sformatf("blink_f%0d", f + 1), 32'({r4, g4, b4}), 32'(blink_exp[f]));
        end

        // video_on follows the pixel through the pipeline
        blink = 1'b0;
        move(10, 10);
        check("von_on", 32'({r4, g4, b4}), 32'h00F);
        von = 1'b0;
        @(negedge clk_d); check("von_off_d1", 32'({r4, g4, b4}), 32'h00F);
        @(negedge clk_d); check("von_off_d2", 32'({r4, g4, b4}), 32'h000);
        von = 1'b1;
        @(negedge clk_d); check("von_on_d1", 32'({r4, g4, b4}), 32'h000);
        @(negedge clk_d); check("von_on_d2", 32'({r4, g4, b4}), 32'h00F);

        // 3-column instance: out-of-range cursor and grid edge
        board3 = '0;
        sel3 = 4'd12;
        snap();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                move(c * 160 + 50, r * 120 + 50);
                check($sformatf("c3_r%0dc%0d", r, c), 32'({r3, g3, b3}),
                      ((r + c) % 2 == 0) ? 32'hFFF : 32'h000);
            end
        end
        move(500, 10);  check("c3_outside", 32'({r3, g3, b3}), 32'h000);
        board3 = 24'h00_0C00;
        snap();
        move(370, 170); check("c3_k5",      32'({r3, g3, b3}), 32'hFF0);
        move(210, 170); check("c3_k4",      32'({r3, g3, b3}), 32'hFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
